// File: rtl/axis_fifo.sv
// Single-clock AXI4-Stream FIFO carrying {tlast,tdata} per beat, first-word-fall-through.
// The head entry is presented on m_* whenever the FIFO holds at least one beat.
module axis_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                     s_aclk,
  input  logic                     s_areset_n,
  input  logic [DATA_WIDTH-1:0]    s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  output logic [DATA_WIDTH-1:0]    m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [$clog2(DEPTH):0]   fill_count
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_WIDTH:0] mem_reg [DEPTH];
  logic [ADDR_W:0]     wr_ptr_reg;
  logic [ADDR_W:0]     rd_ptr_reg;
  logic                ready_en_reg;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic [DATA_WIDTH:0] head;

  // Pointer MSB is a wrap flag: equal low bits with differing MSBs means full.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                 (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);

  assign s_tready   = ready_en_reg & ~full;
  assign m_tvalid   = ~empty;
  assign push       = s_tvalid & s_tready;
  assign pop        = m_tvalid & m_tready;
  assign fill_count = wr_ptr_reg - rd_ptr_reg;

  assign head    = mem_reg[rd_ptr_reg[ADDR_W-1:0]];
  assign m_tdata = m_tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign m_tlast = m_tvalid ? head[DATA_WIDTH] : 1'b0;

  always_ff @(posedge s_aclk or negedge s_areset_n) begin
    if (!s_areset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage is deliberately left unreset; pointers alone define validity.
  always_ff @(posedge s_aclk) begin
    if (push) mem_reg[wr_ptr_reg[ADDR_W-1:0]] <= {s_tlast, s_tdata};
  end

endmodule

// File: tb/tb_axis_fifo.sv
// Bench for axis_fifo: vector table for basic push/pop, directed corner sequences,
// and a scoreboard monitor that checks every popped beat and hold stability.
module tb_axis_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          s_aclk = 1'b0;
  logic          s_areset_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic [4:0]    fill_count;

  axis_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .s_aclk(s_aclk), .s_areset_n(s_areset_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .fill_count(fill_count)
  );

  always #5 s_aclk = ~s_aclk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop = 0;
  logic [DW:0] sb[$];

  typedef struct {
    logic          vld;
    logic [DW-1:0] data;
    logic          last;
    logic          rdy;
    logic [4:0]    fill;
    logic          mv;
    logic [DW-1:0] md;
    logic          ml;
    logic          sr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge s_aclk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    while (m_tvalid && k < 100) begin
      step();
      k++;
    end
    check("drain_empty", m_tvalid, 1'b0);
    check("drain_sb_empty", sb.size(), 0);
    m_tready = 1'b0;
  endtask

  function automatic vec_t mk(logic vld, logic [DW-1:0] data, logic last, logic rdy,
                              logic [4:0] fill, logic mv, logic [DW-1:0] md, logic ml);
    vec_t v;
    v.vld = vld; v.data = data; v.last = last; v.rdy = rdy;
    v.fill = fill; v.mv = mv; v.md = md; v.ml = ml; v.sr = 1'b1;
    return v;
  endfunction

  // Monitor: samples pre-edge values at each rising edge.
  initial begin
    logic        hold_pending;
    logic [DW:0] hold_beat;
    logic [DW:0] exp_beat;
    hold_pending = 1'b0;
    hold_beat = '0;
    forever begin
      @(posedge s_aclk);
      if (!s_areset_n) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("hold_valid", m_tvalid, 1'b1);
          check("hold_beat", {m_tlast, m_tdata}, hold_beat);
        end
        if (m_tvalid && m_tready) begin
          n_pop++;
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: actual=%0h required=none", {m_tlast, m_tdata});
          end else begin
            exp_beat = sb.pop_front();
            check("sb_beat", {m_tlast, m_tdata}, exp_beat);
          end
        end
        if (s_tvalid && s_tready) sb.push_back({s_tlast, s_tdata});
        hold_pending = m_tvalid && !m_tready;
        hold_beat = {m_tlast, m_tdata};
      end
    end
  end

  initial begin
    int   sent;
    int   cycles;
    int   pop0;
    logic acc;

    vecs[0]  = mk(1, 32'hA1, 0, 0, 1, 1, 32'hA1, 0);
    vecs[1]  = mk(1, 32'hB2, 0, 0, 2, 1, 32'hA1, 0);
    vecs[2]  = mk(1, 32'hC3, 0, 0, 3, 1, 32'hA1, 0);
    vecs[3]  = mk(1, 32'hD4, 1, 0, 4, 1, 32'hA1, 0);
    vecs[4]  = mk(0, 32'h00, 0, 1, 3, 1, 32'hB2, 0);
    vecs[5]  = mk(0, 32'h00, 0, 1, 2, 1, 32'hC3, 0);
    vecs[6]  = mk(0, 32'h00, 0, 1, 1, 1, 32'hD4, 1);
    vecs[7]  = mk(0, 32'h00, 0, 1, 0, 0, 32'h00, 0);
    vecs[8]  = mk(1, 32'hE5, 0, 1, 1, 1, 32'hE5, 0);
    vecs[9]  = mk(1, 32'hF6, 1, 1, 1, 1, 32'hF6, 1);
    vecs[10] = mk(0, 32'h00, 0, 1, 0, 0, 32'h00, 0);

    // Reset held for 10 cycles, then released between edges.
    repeat (10) @(posedge s_aclk);
    #1;
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tdata", m_tdata, 32'h0);
    check("rst_fill", fill_count, 5'd0);
    s_areset_n = 1'b1;
    #1;
    check("rel_s_tready_before_edge", s_tready, 1'b0);
    step();
    check("rel_s_tready_after_edge", s_tready, 1'b1);

    // Table-driven push/pop, including push+pop and push-into-empty.
    for (int i = 0; i < 11; i++) begin
      s_tvalid = vecs[i].vld;
      s_tdata  = vecs[i].data;
      s_tlast  = vecs[i].last;
      m_tready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_fill", i), fill_count, vecs[i].fill);
      check($sformatf("vec%0d_m_tvalid", i), m_tvalid, vecs[i].mv);
      check($sformatf("vec%0d_m_tdata", i), m_tdata, vecs[i].md);
      check($sformatf("vec%0d_m_tlast", i), m_tlast, vecs[i].ml);
      check($sformatf("vec%0d_s_tready", i), s_tready, vecs[i].sr);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b0;

    // Fill to DEPTH, hold a 17th beat, free one slot.
    for (int i = 0; i < DEPTH; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'h100 + i;
      s_tlast  = (i == DEPTH - 1);
      step();
    end
    check("full_fill", fill_count, 5'd16);
    check("full_s_tready", s_tready, 1'b0);
    s_tdata = 32'h999;
    s_tlast = 1'b1;
    repeat (3) step();
    check("full_hold_fill", fill_count, 5'd16);
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    check("full_pop_fill", fill_count, 5'd15);
    check("full_pop_s_tready", s_tready, 1'b1);
    step();
    check("full_17th_fill", fill_count, 5'd16);
    drain();

    // Continuous streaming across several pointer wraps.
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_tdata = 32'h1000 + i;
      s_tlast = (i % 8 == 7);
      step();
      check($sformatf("stream%0d_fill", i), fill_count, 5'd1);
    end
    s_tvalid = 1'b0;
    step();
    check("stream_end_fill", fill_count, 5'd0);
    m_tready = 1'b0;

    // Reset asserted with 5 beats stored.
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'h2000 + i;
      s_tlast  = 1'b0;
      step();
    end
    s_tvalid = 1'b0;
    check("pre_rst_fill", fill_count, 5'd5);
    #2;
    s_areset_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_m_tvalid", m_tvalid, 1'b0);
    check("midrst_fill", fill_count, 5'd0);
    check("midrst_m_tdata", m_tdata, 32'h0);
    check("midrst_s_tready", s_tready, 1'b0);
    repeat (2) step();
    s_areset_n = 1'b1;
    step();
    s_tvalid = 1'b1;
    s_tdata  = 32'h55;
    s_tlast  = 1'b0;
    step();
    s_tvalid = 1'b0;
    check("postrst_m_tvalid", m_tvalid, 1'b1);
    check("postrst_m_tdata", m_tdata, 32'h55);
    check("postrst_fill", fill_count, 5'd1);
    drain();

    // Random valid/ready traffic against the scoreboard.
    sent = 0;
    cycles = 0;
    pop0 = n_pop;
    while (sent < 1000 && cycles < 20000) begin
      if (!s_tvalid) begin
        s_tvalid = 1'($urandom_range(0, 1));
        s_tdata  = $urandom;
        s_tlast  = ($urandom_range(0, 3) == 0);
      end
      m_tready = 1'($urandom_range(0, 1));
      acc = s_tvalid && s_tready;
      step();
      cycles++;
      if (acc) begin
        sent++;
        s_tvalid = 1'b0;
      end
    end
    check("rand_sent", sent, 1000);
    drain();
    check("rand_popped", n_pop - pop0, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
